// File: rtl/mult8_seq_accum.sv
// Sequential 8x8 unsigned multiplier: reuses one external 4x4 multiplier over four
// nibble products (LL, LH, HL, HH) and accumulates them into a 16-bit result.
module mult8_seq_accum #(
  parameter int SKIP_ZERO = 1,
  parameter int HALF_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   A,
  input  logic [2*HALF_W-1:0]   B,
  output logic [HALF_W-1:0]     mul_a,
  output logic [HALF_W-1:0]     mul_b,
  input  logic [2*HALF_W-1:0]   mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   P,
  output logic                  busy
);

  localparam int OW = 2 * HALF_W;
  localparam int PW = 4 * HALF_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_LH   = 3'd2,
    S_HL   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state_q;
  logic [OW-1:0]   a_q;
  logic [OW-1:0]   b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   p_q;
  logic            out_valid_q;
  logic [PW-1:0]   term_s;
  logic            skip_s;

  // Nibble select and weighted partial product, decoded from state and latched operands only.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    term_s = '0;
    case (state_q)
      S_LL: begin
        mul_a  = a_q[HALF_W-1:0];
        mul_b  = b_q[HALF_W-1:0];
        term_s = PW'(mul_p);
      end
      S_LH: begin
        mul_a  = a_q[HALF_W-1:0];
        mul_b  = b_q[OW-1:HALF_W];
        term_s = PW'(mul_p) << HALF_W;
      end
      S_HL: begin
        mul_a  = a_q[OW-1:HALF_W];
        mul_b  = b_q[HALF_W-1:0];
        term_s = PW'(mul_p) << HALF_W;
      end
      S_HH: begin
        mul_a  = a_q[OW-1:HALF_W];
        mul_b  = b_q[OW-1:HALF_W];
        term_s = PW'(mul_p) << OW;
      end
      default: begin
        mul_a  = '0;
        mul_b  = '0;
        term_s = '0;
      end
    endcase
    acc_d  = acc_q + term_s;
    skip_s = (SKIP_ZERO != 32'sd0) && ((A == '0) || (B == '0));
  end

  // Sequencer, accumulator and registered result/handshake state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            acc_q <= '0;
            if (skip_s) begin
              p_q         <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_LL;
            end
          end
        end
        S_LL: begin
          acc_q   <= acc_d;
          state_q <= S_LH;
        end
        S_LH: begin
          acc_q   <= acc_d;
          state_q <= S_HL;
        end
        S_HL: begin
          acc_q   <= acc_d;
          state_q <= S_HH;
        end
        S_HH: begin
          acc_q       <= acc_d;
          p_q         <= acc_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign P         = p_q;

endmodule

// File: tb/tb_mult8_seq_accum.sv
// Directed bench for mult8_seq_accum with an ideal 4x4 multiplier model; a second
// instance with SKIP_ZERO=0 covers the non-skipping zero-operand path.
module tb_mult8_seq_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;
  logic        busy;

  logic        ns_in_valid;
  logic        ns_in_ready;
  logic [3:0]  ns_mul_a;
  logic [3:0]  ns_mul_b;
  logic [7:0]  ns_mul_p;
  logic        ns_out_valid;
  logic        ns_out_ready;
  logic [15:0] ns_P;
  logic        ns_busy;

  int          n_chk;
  int          n_fail;
  int          lat;
  logic [7:0]  seq [4];
  int          n_seq;

  assign mul_p    = 8'(mul_a) * 8'(mul_b);
  assign ns_mul_p = 8'(ns_mul_a) * 8'(ns_mul_b);

  mult8_seq_accum #(.SKIP_ZERO(1), .HALF_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
  );

  mult8_seq_accum #(.SKIP_ZERO(0), .HALF_W(4)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
    .A(A), .B(B), .mul_a(ns_mul_a), .mul_b(ns_mul_b), .mul_p(ns_mul_p),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .P(ns_P), .busy(ns_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid on the main instance, logging nibble pairs seen while busy.
  task automatic wait_valid(output int l);
    l = 1;
    n_seq = 0;
    while (out_valid !== 1'b1 && l < 20) begin
      if (busy === 1'b1 && n_seq < 4) begin
        seq[n_seq] = {mul_a, mul_b};
        n_seq++;
      end
      tick();
      l++;
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                       input logic [15:0] exp_p, input string tag);
    int l;
    check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(l);
    check({tag, "_latency"}, 16'(l), 16'(exp_lat));
    check({tag, "_P"}, P, exp_p);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 16'(out_valid), 16'h0);
    check({tag, "_idle"}, 16'(in_ready), 16'h1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
    out_ready = 1'b0;
    ns_in_valid = 1'b0;
    ns_out_ready = 1'b0;

    // Reset held two cycles with a valid pair presented.
    tick();
    tick();
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_P", P, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_mul_a", 16'(mul_a), 16'h0);
    check("rst_mul_b", 16'(mul_b), 16'h0);
    check("rst_ns_busy", 16'(ns_busy), 16'h0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Basic product and nibble sequence.
    do_op(8'h12, 8'h34, 5, 16'h03A8, "basic");
    check("seq_count", 16'(n_seq), 16'd4);
    check("seq_LL", 16'(seq[0]), 16'h0024);
    check("seq_LH", 16'(seq[1]), 16'h0023);
    check("seq_HL", 16'(seq[2]), 16'h0014);
    check("seq_HH", 16'(seq[3]), 16'h0013);

    do_op(8'hFF, 8'hFF, 5, 16'hFE01, "max");
    do_op(8'h80, 8'h02, 5, 16'h0100, "msb");

    // Backpressure with a new pair waiting.
    A = 8'h12;
    B = 8'h34;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_first_P", P, 16'h03A8);
    A = 8'h05;
    B = 8'h07;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("bp_hold_P", P, 16'h03A8);
      check("bp_hold_in_ready", 16'(in_ready), 16'h0);
      check("bp_hold_out_valid", 16'(out_valid), 16'h1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_latency", 16'(lat), 16'd5);
    check("bp_next_P", P, 16'h0023);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Zero skip on the default instance.
    do_op(8'h00, 8'h9C, 1, 16'h0000, "skip");
    check("skip_seq_count", 16'(n_seq), 16'd0);

    // Same zero operand on the non-skipping instance.
    A = 8'h00;
    B = 8'h9C;
    ns_in_valid = 1'b1;
    tick();
    ns_in_valid = 1'b0;
    lat = 1;
    while (ns_out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("noskip_latency", 16'(lat), 16'd5);
    check("noskip_P", ns_P, 16'h0000);
    check("noskip_in_ready", 16'(ns_in_ready), 16'h0);
    ns_out_ready = 1'b1;
    tick();
    ns_out_ready = 1'b0;
    check("noskip_idle", 16'(ns_in_ready), 16'h1);

    // Leave a nonzero P, then abort an operation in HL.
    do_op(8'h03, 8'h05, 5, 16'h000F, "pre_abort");
    A = 8'h12;
    B = 8'h34;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("hl_mul_a", 16'(mul_a), 16'h1);
    check("hl_mul_b", 16'(mul_b), 16'h4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_out_valid", 16'(out_valid), 16'h0);
    check("abort_P", P, 16'h0000);
    do_op(8'h0A, 8'h0B, 5, 16'h006E, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult8_seq_accum.md
Name: mult8_seq_accum

Overview:
- Sequential 8x8 unsigned multiplier stage that sits directly downstream of the 4x4 multiplier built from 2x2 RL-derived cores.
- It time-multiplexes one external 4x4 multiplier over four nibble products and accumulates them into a 16-bit result.
- It has a valid/ready handshake on both sides, so 8-bit operand streams can be checked against the composed 4x4 datapath without four multiplier instances.

Parameters:
- SKIP_ZERO, 1: when 1, an operand pair with A==0 or B==0 bypasses the nibble sequence and completes in one cycle with P=0. When 0, every pair runs the full sequence.
- HALF_W, 4: nibble width. Fixed at 4; any other value is unsupported.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept an operand pair
- A  input  8  multiplicand, unsigned
- B  input  8  multiplier, unsigned
- mul_a  output  4  operand A nibble driven to the external 4x4 multiplier
- mul_b  output  4  operand B nibble driven to the external 4x4 multiplier
- mul_p  input  8  product returned combinationally by the external 4x4 multiplier, sampled the same cycle
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- P  output  16  product A*B
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low; all state updates on the rising edge of clk.
- Reset values (rst_n low at a rising edge, checked on the next cycle): state=IDLE, P=0, out_valid=0, in_ready=1, busy=0, accumulator=0, latched operands=0.
- Reset mid-operation: reset wins over all other events. It aborts any operation in progress, drops any pending result, and returns to IDLE.
- States: IDLE, LL, LH, HL, HH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch A and B and clear the accumulator.
  - If SKIP_ZERO=1 and (A==0 or B==0), go to DONE with P=0.
  - Otherwise go to LL.
- LL: mul_a=A[3:0], mul_b=B[3:0]; acc += mul_p; go to LH.
- LH: mul_a=A[3:0], mul_b=B[7:4]; acc += mul_p<<4; go to HL.
- HL: mul_a=A[7:4], mul_b=B[3:0]; acc += mul_p<<4; go to HH.
- HH:
  - mul_a=A[7:4], mul_b=B[7:4].
  - P <= acc + (mul_p<<8), computed as a 16-bit sum. No overflow is possible since 255*255 < 2^16.
  - Go to DONE.
- DONE:
  - out_valid=1 and P is held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - out_valid and P must not change while out_ready is low.
- mul_a and mul_b are driven 0 in IDLE and DONE. They are decoded combinationally from the state and the latched operands only, never from live A/B.
- in_ready=0 in all states except IDLE. A new pair cannot be accepted in the same cycle a result is consumed, so the minimum issue interval is 6 cycles (2 with skip).
- Latency, measured from the accept edge to out_valid high: 5 cycles for a full sequence, 1 cycle for a skipped pair.
- Unknown or illegal state encoding returns to IDLE.
- A and B are ignored while in_ready=0.

Test Plan:
- Reset: hold rst_n low 2 cycles with in_valid=1 and A=B=8'hFF -> in_ready=1, out_valid=0, P=0, busy=0, mul_a=mul_b=0.
- Basic operation, with an ideal bench multiplier (mul_p=mul_a*mul_b):
  - A=8'h12, B=8'h34 -> out_valid 5 cycles after accept, P=16'h03A8.
  - mul_a/mul_b sequence is (2,4), (2,3), (1,4), (1,3).
- Maximum operands: A=B=8'hFF -> P=16'hFE01. Then A=8'h80, B=8'h02 -> P=16'h0100.
- Backpressure: out_ready low 7 cycles after out_valid, with in_valid high and a new pair (A=8'h05, B=8'h07) presented:
  - P stays at 16'h03A8 and in_ready stays 0 throughout.
  - After out_ready pulses, the next result is 16'h0023.
- Zero skip:
  - SKIP_ZERO=1, A=8'h00, B=8'h9C -> out_valid 1 cycle after accept, P=0, mul_a/mul_b stay 0.
  - SKIP_ZERO=0 with the same operands -> 5-cycle latency, P=0.
- Reset mid-operation: assert rst_n low in state HL -> next cycle IDLE, out_valid=0, P=0. A following A=8'h0A, B=8'h0B yields P=16'h006E.
